// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO and runs multi-cycle MULT/DIV.
// Results are computed at issue and committed to HI/LO when the busy countdown expires.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUop_i,
    input  logic [31:0] E_A_i,
    input  logic [31:0] E_B_i,
    output logic        E_start_o,
    output logic        E_busy_o,
    output logic [31:0] E_MDUout_o,
    output logic [31:0] HI_o,
    output logic [31:0] LO_o
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    logic            busy_q, busy_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic            pend_wr_q, pend_wr_d;

    logic        is_md_op;
    logic [63:0] ext_a, ext_b, prod;
    logic        sdiv, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, dvd, dvs, dvs_safe, uq, ur, quot, rem;

    assign is_md_op = (E_MDUop_i == OpMult) || (E_MDUop_i == OpMultu) ||
                      (E_MDUop_i == OpDiv)  || (E_MDUop_i == OpDivu);

    // Sign- or zero-extend to 64 bits so one unsigned multiplier serves MULT and MULTU.
    assign ext_a = {{32{E_A_i[31] & (E_MDUop_i == OpMult)}}, E_A_i};
    assign ext_b = {{32{E_B_i[31] & (E_MDUop_i == OpMult)}}, E_B_i};
    assign prod  = ext_a * ext_b;

    // Signed division on magnitudes; 0x80000000 / -1 wraps naturally to 0x80000000 rem 0.
    assign sdiv     = (E_MDUop_i == OpDiv);
    assign a_neg    = sdiv & E_A_i[31];
    assign b_neg    = sdiv & E_B_i[31];
    assign a_mag    = a_neg ? (~E_A_i + 32'd1) : E_A_i;
    assign b_mag    = b_neg ? (~E_B_i + 32'd1) : E_B_i;
    assign dvd      = a_mag;
    assign dvs      = b_mag;
    assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    assign uq       = dvd / dvs_safe;
    assign ur       = dvd % dvs_safe;
    assign quot     = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    assign rem      = a_neg ? (~ur + 32'd1) : ur;

    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        if (busy_q) begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                busy_d = 1'b0;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end else begin
            case (E_MDUop_i)
                OpMult, OpMultu: begin
                    pend_hi_d = prod[63:32];
                    pend_lo_d = prod[31:0];
                    pend_wr_d = 1'b1;
                    cnt_d     = CntW'(MULT_CYCLES);
                    busy_d    = 1'b1;
                end
                OpDiv, OpDivu: begin
                    pend_hi_d = rem;
                    pend_lo_d = quot;
                    pend_wr_d = (E_B_i != 32'd0);
                    cnt_d     = CntW'(DIV_CYCLES);
                    busy_d    = 1'b1;
                end
                OpMthi:  hi_d = E_A_i;
                OpMtlo:  lo_d = E_A_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    always_comb begin
        case (E_MDUop_i)
            OpMfhi:  E_MDUout_o = hi_q;
            OpMflo:  E_MDUout_o = lo_q;
            default: E_MDUout_o = 32'd0;
        endcase
    end

    assign E_start_o = is_md_op & ~busy_q;
    assign E_busy_o  = busy_q;
    assign HI_o      = hi_q;
    assign LO_o      = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: expected HI/LO pushed at issue, popped and compared at completion.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        start, busy;
    logic [31:0] mdu_out, hi, lo;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int k_cyc    = 0;
    logic [63:0] sb[$];

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_MDUop_i  (op),
        .E_A_i      (a),
        .E_B_i      (b),
        .E_start_o  (start),
        .E_busy_o   (busy),
        .E_MDUout_o (mdu_out),
        .HI_o       (hi),
        .LO_o       (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start op, check E_start_o in the issue cycle, push expectation, clock it in.
    task automatic issue(input string tag, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        op = o; a = x; b = y;
        #1;
        check({tag, "_start"}, {31'd0, start}, 32'd1);
        sb.push_back({ehi, elo});
        tick();
        k_cyc = cyc;
        op = 4'd0;
        check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic finish(input string tag, input int n);
        logic [63:0] e;
        int guard;
        guard = 0;
        while (busy && guard < 200) begin
            tick();
            guard++;
        end
        check({tag, "_cycles"}, cyc - k_cyc, n);
        e = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        check({tag, "_hi"}, hi, e[63:32]);
        check({tag, "_lo"}, lo, e[31:0]);
    endtask

    initial begin
        logic [63:0] drop;
        #3;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        #20 reset = 1'b1;
        tick();

        issue("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        finish("mult", 5);

        issue("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        op = 4'd5;
        #1;
        check("mfhi_stale", mdu_out, 32'hFFFF_FFFF);
        check("no_start_busy", {31'd0, start}, 32'd0);
        op = 4'd0;
        finish("multu", 5);
        op = 4'd5;
        #1;
        check("mfhi_new", mdu_out, 32'hFFFF_FFFE);
        op = 4'd6;
        #1;
        check("mflo_new", mdu_out, 32'h0000_0001);
        op = 4'd0;
        #1;
        check("none_out", mdu_out, 32'd0);

        issue("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        finish("div", 10);
        issue("divu", 4'd4, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
        finish("divu", 10);

        op = 4'd7; a = 32'h1234_5678;
        tick();
        op = 4'd0;
        check("mthi", hi, 32'h1234_5678);
        issue("div0", 4'd3, 32'd99, 32'd0, 32'h1234_5678, 32'h7FFF_FFFC);
        finish("div0", 10);
        issue("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        finish("divovf", 10);

        issue("div_ign", 4'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        tick();
        op = 4'd8; a = 32'hAAAA_0000;
        tick();
        op = 4'd1; a = 32'd9; b = 32'd9;
        #1;
        check("ign_start", {31'd0, start}, 32'd0);
        tick();
        op = 4'd0;
        finish("div_ign", 10);
        issue("mult_after", 4'd1, 32'd6, 32'd7, 32'd0, 32'd42);
        finish("mult_after", 5);

        issue("mult_rst", 4'd1, 32'd3, 32'd4, 32'd0, 32'd12);
        tick();
        tick();
        #3;
        reset = 1'b0;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        drop = sb.pop_front();
        #2 reset = 1'b1;
        op = 4'd8; a = 32'd5;
        tick();
        op = 4'd0;
        check("mtlo_after_rst", lo, 32'd5);
        check("idle_after_rst", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
